// File: rtl/dbg_access_port_if.sv
// Command/response handshake bundle for the debug access port.
// master = host side (bench/driver), slave = dbg_access_port.
interface dbg_access_port_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_target;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LEN_W-1:0]  req_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_last;

    modport master (
        output req_valid, req_target, req_write, req_addr,
        output req_wdata, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_last
    );

    modport slave (
        input  req_valid, req_target, req_write, req_addr,
        input  req_wdata, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_last
    );
endinterface

// File: rtl/dbg_access_port.sv
// Backdoor access controller: halts the core, runs single/burst IMEM/DMEM/REG
// accesses, one response per beat. Optional DAP_ADDR_CHECK_EN: range errors.
module dbg_access_port #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    parameter int NUM_REGS   = 32,
    parameter int LEN_W      = 4,
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 10,
    localparam int IW = $clog2(IMEM_DEPTH),
    localparam int DW = $clog2(DMEM_DEPTH),
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    dbg_access_port_if.slave  bus,
    output logic              halt_req_o,
    input  logic              halt_ack_i,
    output logic              imem_we_o,
    output logic [IW-1:0]     imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic              dmem_we_o,
    output logic              dmem_re_o,
    output logic [DW-1:0]     dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic [RW-1:0]     reg_rd_addr_o,
    input  logic [DATA_W-1:0] reg_rd_data_i,
    output logic              busy_o
);
    // Extra LEN_W bits keep burst addresses un-wrapped for range checking.
    localparam int XW   = ADDR_W + LEN_W;
    localparam int CW   = $clog2(MEM_RD_LAT + 1);
    localparam int AMAX = (IW > DW) ? ((IW > RW) ? IW : RW)
                                    : ((DW > RW) ? DW : RW);
    localparam logic [XW-1:0] IMASK = XW'((1 << IW) - 1);
    localparam logic [XW-1:0] DMASK = XW'((1 << DW) - 1);
    localparam logic [XW-1:0] RMASK = XW'((1 << RW) - 1);

    typedef enum logic [2:0] {
        IDLE, HALT, ACCESS, WAIT_RD, RESP, RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        tgt_q;
    logic              wr_q;
    logic [XW-1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [XW-1:0] depth, mask, idx, addr_nx;
    logic          in_range, legal, last, rd_done;
    logic          unused_hi;

    always_comb begin
        depth = '0;
        mask  = '0;
        case (tgt_q)
            2'd0: begin depth = XW'(IMEM_DEPTH); mask = IMASK; end
            2'd1: begin depth = XW'(DMEM_DEPTH); mask = DMASK; end
            2'd2: begin depth = XW'(NUM_REGS);   mask = RMASK; end
            default: ;
        endcase
    end

    assign idx       = addr_q & mask;
    assign unused_hi = ^idx[XW-1:AMAX];
    assign last      = (beat_q == len_q);
    assign rd_done   = (cnt_q == CW'(MEM_RD_LAT - 1));

`ifdef DAP_ADDR_CHECK_EN
    assign in_range = (addr_q < depth);
    assign addr_nx  = addr_q + 1'b1;
`else
    assign in_range = 1'b1;
    assign addr_nx  = (idx == depth - 1'b1) ? '0 : idx + 1'b1;
`endif

    assign legal = in_range &&
                   ((tgt_q == 2'd0 && wr_q) || (tgt_q == 2'd1) ||
                    (tgt_q == 2'd2 && !wr_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = HALT;
            HALT:    if (halt_ack_i) state_d = ACCESS;
            ACCESS:  state_d = (legal && !wr_q) ? WAIT_RD : RESP;
            WAIT_RD: if (rd_done) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = last ? RELEASE : ACCESS;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.req_valid) begin
                    tgt_q   <= bus.req_target;
                    wr_q    <= bus.req_write;
                    addr_q  <= XW'(bus.req_addr);
                    wdata_q <= bus.req_wdata;
                    len_q   <= bus.req_len;
                    beat_q  <= '0;
                end
                ACCESS: begin
                    err_q   <= !legal;
                    rdata_q <= '0;
                    cnt_q   <= '0;
                end
                WAIT_RD: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rd_done)
                        rdata_q <= (tgt_q == 2'd1) ? dmem_rdata_i
                                                   : reg_rd_data_i;
                end
                RESP: if (bus.rsp_ready && !last) begin
                    beat_q <= beat_q + 1'b1;
                    addr_q <= addr_nx;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.rsp_last  = 1'b0;
        halt_req_o    = 1'b0;
        imem_we_o     = 1'b0;
        imem_addr_o   = '0;
        imem_wdata_o  = '0;
        dmem_we_o     = 1'b0;
        dmem_re_o     = 1'b0;
        dmem_addr_o   = '0;
        dmem_wdata_o  = '0;
        reg_rd_addr_o = '0;
        busy_o        = (state_q != IDLE);
        unique case (state_q)
            IDLE: bus.req_ready = !rst;
            HALT: halt_req_o = 1'b1;
            ACCESS, WAIT_RD: begin
                halt_req_o = 1'b1;
                if (legal) begin
                    unique case (tgt_q)
                        2'd0: begin
                            imem_addr_o  = idx[IW-1:0];
                            imem_we_o    = (state_q == ACCESS);
                            imem_wdata_o = wdata_q;
                        end
                        2'd1: begin
                            dmem_addr_o  = idx[DW-1:0];
                            dmem_we_o    = (state_q == ACCESS) && wr_q;
                            dmem_re_o    = (state_q == ACCESS) && !wr_q;
                            dmem_wdata_o = wr_q ? wdata_q : '0;
                        end
                        default: reg_rd_addr_o = idx[RW-1:0];
                    endcase
                end
            end
            RESP: begin
                halt_req_o    = 1'b1;
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_q;
                bus.rsp_err   = err_q;
                bus.rsp_last  = last;
            end
            default: ;
        endcase
    end
endmodule
